// File: rtl/vblank_fetch_arbiter.sv
// Shares the dmem port between the processor M stage and a vblank snapshot engine that
// copies NUM_WORDS game-state words into the renderer's shadow buffer once per frame.
module vblank_fetch_arbiter #(
    parameter logic [31:0] BASE_ADDR    = 32'd1000,
    parameter int unsigned NUM_WORDS    = 16,
    parameter int unsigned IDX_W        = 4,
    parameter int unsigned STARVE_LIMIT = 4
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             screen_end,
    input  logic             proc_req,
    input  logic [31:0]      proc_addr,
    input  logic [31:0]      proc_data,
    input  logic             proc_wren,
    output logic             proc_stall,
    output logic [31:0]      proc_q,
    output logic [31:0]      mem_addr,
    output logic [31:0]      mem_data,
    output logic             mem_wren,
    input  logic [31:0]      mem_q,
    output logic             snap_we,
    output logic [IDX_W-1:0] snap_idx,
    output logic [31:0]      snap_data,
    output logic             busy,
    output logic             done,
    output logic             overrun
);

    localparam int unsigned IW = IDX_W + 1;
    localparam int unsigned SW = (STARVE_LIMIT < 1) ? 1 : $clog2(STARVE_LIMIT + 1);
    localparam logic [SW-1:0] STARVE_MAX = SW'(STARVE_LIMIT);
    localparam logic [IW-1:0] LAST_IDX   = IW'(NUM_WORDS - 1);

    typedef enum logic [1:0] {StIdle, StFetch, StDrain} state_e;

    state_e           state_q;
    logic             screen_end_q;
    logic [IW-1:0]    issue_idx_q;
    logic [SW-1:0]    starve_cnt_q;
    logic             rd_valid_q;
    logic [IDX_W-1:0] rd_idx_q;
    logic             overrun_q;

    logic start_edge;
    logic engine_go;

    // The engine takes the port whenever the processor is idle or has starved it long enough.
    always_comb begin
        start_edge = screen_end & ~screen_end_q;
        engine_go  = (state_q == StFetch) && !(proc_req && (starve_cnt_q < STARVE_MAX));
        busy       = (state_q != StIdle);
        done       = (state_q == StDrain);
        proc_stall = engine_go & proc_req;
        mem_addr   = engine_go ? (BASE_ADDR + 32'(issue_idx_q)) : proc_addr;
        mem_data   = proc_data;
        mem_wren   = proc_wren & ~engine_go;
        proc_q     = mem_q;
        snap_we    = rd_valid_q;
        snap_idx   = rd_idx_q;
        snap_data  = mem_q;
        overrun    = overrun_q;
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q      <= StIdle;
            screen_end_q <= 1'b0;
            issue_idx_q  <= '0;
            starve_cnt_q <= '0;
            rd_valid_q   <= 1'b0;
            rd_idx_q     <= '0;
            overrun_q    <= 1'b0;
        end else begin
            screen_end_q <= screen_end;
            rd_valid_q   <= engine_go;
            if (engine_go) begin
                rd_idx_q <= issue_idx_q[IDX_W-1:0];
            end
            if (start_edge && busy) begin
                overrun_q <= 1'b1;
            end
            case (state_q)
                StIdle: begin
                    if (start_edge) begin
                        state_q      <= StFetch;
                        issue_idx_q  <= '0;
                        starve_cnt_q <= '0;
                    end
                end
                StFetch: begin
                    if (engine_go) begin
                        starve_cnt_q <= '0;
                        issue_idx_q  <= issue_idx_q + 1'b1;
                        if (issue_idx_q == LAST_IDX) begin
                            state_q <= StDrain;
                        end
                    end else begin
                        starve_cnt_q <= starve_cnt_q + 1'b1;
                    end
                end
                StDrain: state_q <= StIdle;
                default: state_q <= StIdle;
            endcase
        end
    end

endmodule

// File: tb/tb_vblank_fetch_arbiter.sv
// Directed bench for vblank_fetch_arbiter: dmem and shadow-buffer models plus a per-cycle monitor.
module tb_vblank_fetch_arbiter;

    localparam int unsigned NW    = 16;
    localparam int unsigned SPAN  = 5;  // STARVE_LIMIT + 1

    logic        clock;
    logic        reset;
    logic        screen_end;
    logic        proc_req;
    logic [31:0] proc_addr;
    logic [31:0] proc_data;
    logic        proc_wren;
    logic        proc_stall;
    logic [31:0] proc_q;
    logic [31:0] mem_addr;
    logic [31:0] mem_data;
    logic        mem_wren;
    logic [31:0] mem_q;
    logic        snap_we;
    logic [3:0]  snap_idx;
    logic [31:0] snap_data;
    logic        busy;
    logic        done;
    logic        overrun;

    vblank_fetch_arbiter dut (
        .clock      (clock),
        .reset      (reset),
        .screen_end (screen_end),
        .proc_req   (proc_req),
        .proc_addr  (proc_addr),
        .proc_data  (proc_data),
        .proc_wren  (proc_wren),
        .proc_stall (proc_stall),
        .proc_q     (proc_q),
        .mem_addr   (mem_addr),
        .mem_data   (mem_data),
        .mem_wren   (mem_wren),
        .mem_q      (mem_q),
        .snap_we    (snap_we),
        .snap_idx   (snap_idx),
        .snap_data  (snap_data),
        .busy       (busy),
        .done       (done),
        .overrun    (overrun)
    );

    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    logic [31:0] mem [0:2047];
    logic [31:0] shadow [0:NW-1];

    initial begin
        for (int i = 0; i < 2048; i++) mem[i] = 32'd0;
        for (int k = 0; k < 16; k++) mem[1000 + k] = 32'(k * 3);
        mem[5] = 32'h0000_ABCD;
    end

    always @(posedge clock) begin
        if (mem_wren) mem[mem_addr[10:0]] <= mem_data;
        mem_q <= mem[mem_addr[10:0]];
    end

    int n_total = 0;
    int n_pass  = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    endtask

    // Monitor: counters restart whenever the main process bumps clr_seq.
    int clr_seq = 0;
    int seen_seq = 0;
    int cyc, we_cnt, idx_err, exp_idx, done_cnt, done_cyc;
    int stall_cnt, stall_pair, stall_bad, wren_stall, fetch_n, pat_err;
    logic prev_stall;

    always @(negedge clock) begin
        if (clr_seq != seen_seq) begin
            seen_seq = clr_seq;
            cyc = 0; we_cnt = 0; idx_err = 0; exp_idx = 0; done_cnt = 0; done_cyc = -1;
            stall_cnt = 0; stall_pair = 0; stall_bad = 0; wren_stall = 0;
            fetch_n = 0; pat_err = 0; prev_stall = 1'b0;
            for (int i = 0; i < NW; i++) shadow[i] = 32'hFFFF_FFFF;
        end else begin
            cyc++;
        end
        if (snap_we) begin
            if (snap_idx != 4'(exp_idx)) idx_err++;
            exp_idx++;
            we_cnt++;
            shadow[snap_idx] = snap_data;
        end
        if (proc_stall) begin
            stall_cnt++;
            if (prev_stall) stall_pair++;
            if (!busy || done) stall_bad++;
            if (mem_wren) wren_stall++;
        end
        prev_stall = proc_stall;
        if (done) begin
            done_cnt++;
            done_cyc = cyc;
        end
        if (busy && !done) begin
            if (proc_stall != ((fetch_n % SPAN) == SPAN - 1)) pat_err++;
            fetch_n++;
        end
    end

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic shadow_errs(output int errs);
        errs = 0;
        for (int k = 0; k < NW; k++) if (shadow[k] !== 32'(k * 3)) errs++;
    endtask

    // Starts a snapshot: the edge cycle is monitor cycle 0.
    task automatic start_edge();
        step();
        clr_seq++;
        screen_end = 1'b1;
        step();
        screen_end = 1'b0;
    endtask

    int errs;

    initial begin
        reset = 1'b1; screen_end = 1'b0; proc_req = 1'b0;
        proc_addr = 32'd0; proc_data = 32'd0; proc_wren = 1'b0;
        clr_seq++;
        repeat (2) step();
        @(negedge clock);
        check("rst_busy", busy, 1'b0);
        check("rst_done", done, 1'b0);
        check("rst_snap_we", snap_we, 1'b0);
        check("rst_stall", proc_stall, 1'b0);
        check("rst_overrun", overrun, 1'b0);
        check("rst_snap_idx", snap_idx, 4'd0);
        step();
        reset = 1'b0;

        // Processor pass-through in IDLE
        step();
        proc_req = 1'b1; proc_addr = 32'd5;
        @(negedge clock);
        check("pt_mem_addr", mem_addr, 32'd5);
        check("pt_stall", proc_stall, 1'b0);
        step();
        proc_req = 1'b0;
        @(negedge clock);
        check("pt_proc_q", proc_q, 32'h0000_ABCD);
        step();
        proc_req = 1'b1; proc_addr = 32'd6; proc_data = 32'h1234; proc_wren = 1'b1;
        step();
        proc_req = 1'b0; proc_wren = 1'b0;
        @(negedge clock);
        check("pt_store", mem[6], 32'h1234);

        // Uncontended copy
        start_edge();
        repeat (25) step();
        @(negedge clock);
        check("unc_we_cnt", we_cnt, NW);
        check("unc_idx_order", idx_err, 0);
        check("unc_done_cnt", done_cnt, 1);
        check("unc_done_cyc", done_cyc, 17);
        check("unc_stalls", stall_cnt, 0);
        check("unc_busy_end", busy, 1'b0);
        for (int k = 0; k < NW; k++) check($sformatf("unc_word%0d", k), shadow[k], 32'(k * 3));

        // Full contention with a store held on the processor side
        step();
        clr_seq++;
        screen_end = 1'b1; proc_req = 1'b1; proc_addr = 32'd100;
        proc_data = 32'hDEAD; proc_wren = 1'b1;
        step();
        screen_end = 1'b0;
        repeat (95) step();
        proc_req = 1'b0; proc_wren = 1'b0;
        @(negedge clock);
        check("con_we_cnt", we_cnt, NW);
        check("con_done_cnt", done_cnt, 1);
        check("con_done_cyc", done_cyc, 81);
        check("con_pattern", pat_err, 0);
        check("con_stall_cnt", stall_cnt, NW);
        check("con_stall_pair", stall_pair, 0);
        check("con_stall_outside", stall_bad, 0);
        check("con_wren_in_stall", wren_stall, 0);
        shadow_errs(errs);
        check("con_data", errs, 0);
        check("con_proc_store", mem[100], 32'hDEAD);

        // Overrun: second edge at cycle 5
        check("ovr_before", overrun, 1'b0);
        start_edge();
        repeat (4) step();
        screen_end = 1'b1;
        step();
        screen_end = 1'b0;
        repeat (25) step();
        @(negedge clock);
        check("ovr_flag", overrun, 1'b1);
        check("ovr_we_cnt", we_cnt, NW);
        check("ovr_done_cnt", done_cnt, 1);
        check("ovr_done_cyc", done_cyc, 17);
        check("ovr_idx_order", idx_err, 0);
        shadow_errs(errs);
        check("ovr_data", errs, 0);

        // Reset mid-FETCH at cycle 6
        start_edge();
        repeat (5) step();
        reset = 1'b1;
        step();
        reset = 1'b0;
        @(negedge clock);
        check("rmid_busy", busy, 1'b0);
        check("rmid_snap_we", snap_we, 1'b0);
        check("rmid_overrun", overrun, 1'b0);
        repeat (20) step();
        @(negedge clock);
        check("rmid_no_done", done_cnt, 0);
        start_edge();
        repeat (25) step();
        @(negedge clock);
        check("rmid_re_we_cnt", we_cnt, NW);
        check("rmid_re_done", done_cnt, 1);
        check("rmid_re_idx", idx_err, 0);
        shadow_errs(errs);
        check("rmid_re_data", errs, 0);

        // Reset and edge in the same cycle
        step();
        reset = 1'b1; screen_end = 1'b1;
        step();
        reset = 1'b0; screen_end = 1'b0;
        @(negedge clock);
        check("rst_edge_busy", busy, 1'b0);
        repeat (3) step();
        @(negedge clock);
        check("rst_edge_busy_later", busy, 1'b0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
